// File: rtl/calc_input_sequencer.sv
// Operand/opcode entry sequencer for the switch-entry ALU calculator.
// Captures OpA, OpB and OpCode on Enter edges, steps back on Undo edges, and drives the display select.
module calc_input_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Enter,
  input  logic             Undo,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  output logic [OPW-1:0]   OpCode,
  output logic             LoadOpA,
  output logic             LoadOpB,
  output logic             LoadOpCode,
  output logic             ToDisplaySel,
  output logic [2:0]       State
);

  localparam logic [2:0] WAIT_OPA    = 3'd0;
  localparam logic [2:0] LOAD_OPA    = 3'd1;
  localparam logic [2:0] WAIT_OPB    = 3'd2;
  localparam logic [2:0] LOAD_OPB    = 3'd3;
  localparam logic [2:0] WAIT_OP     = 3'd4;
  localparam logic [2:0] LOAD_OP     = 3'd5;
  localparam logic [2:0] SHOW_RESULT = 3'd6;

  logic       enter_q;
  logic       undo_q;
  logic       enter_edge;
  logic       undo_edge;
  logic       press;
  logic [2:0] state_nx;
  logic       cap_a;
  logic       cap_b;
  logic       cap_op;

  assign enter_edge = Enter & ~enter_q;
  assign undo_edge  = Undo & ~undo_q;
  // Undo has priority over Enter when both rise together.
  assign press      = enter_edge & ~undo_edge;

  assign cap_a  = (State == WAIT_OPA) & press;
  assign cap_b  = (State == WAIT_OPB) & press;
  assign cap_op = (State == WAIT_OP)  & press;

  always_comb begin
    state_nx = State;
    case (State)
      WAIT_OPA:    if (press) state_nx = LOAD_OPA;
      LOAD_OPA:    state_nx = WAIT_OPB;
      WAIT_OPB: begin
        if (undo_edge)  state_nx = WAIT_OPA;
        else if (press) state_nx = LOAD_OPB;
      end
      LOAD_OPB:    state_nx = WAIT_OP;
      WAIT_OP: begin
        if (undo_edge)  state_nx = WAIT_OPB;
        else if (press) state_nx = LOAD_OP;
      end
      LOAD_OP:     state_nx = SHOW_RESULT;
      SHOW_RESULT: begin
        if (undo_edge)  state_nx = WAIT_OP;
        else if (press) state_nx = WAIT_OPA;
      end
      default:     state_nx = WAIT_OPA;
    endcase
  end

  // Moore outputs are registered from the next state so they change with State, glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_q      <= 1'b1;
      undo_q       <= 1'b1;
      State        <= WAIT_OPA;
      OpA          <= '0;
      OpB          <= '0;
      OpCode       <= '0;
      LoadOpA      <= 1'b0;
      LoadOpB      <= 1'b0;
      LoadOpCode   <= 1'b0;
      ToDisplaySel <= 1'b0;
    end else begin
      enter_q      <= Enter;
      undo_q       <= Undo;
      State        <= state_nx;
      LoadOpA      <= (state_nx == LOAD_OPA);
      LoadOpB      <= (state_nx == LOAD_OPB);
      LoadOpCode   <= (state_nx == LOAD_OP);
      ToDisplaySel <= (state_nx == SHOW_RESULT);
      if (cap_a)  OpA    <= DataIn;
      if (cap_b)  OpB    <= DataIn;
      if (cap_op) OpCode <= DataIn[OPW-1:0];
    end
  end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: scripted vector table, hand corner sequences and random stimulus
// against a slot-counting reference model.
module tb_calc_input_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] DataIn;
  logic        Enter;
  logic        Undo;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [1:0]  OpCode;
  logic        LoadOpA;
  logic        LoadOpB;
  logic        LoadOpCode;
  logic        ToDisplaySel;
  logic [2:0]  State;

  calc_input_sequencer #(.WIDTH(16), .OPW(2)) dut (
    .clk(clk), .reset_n(reset_n), .DataIn(DataIn), .Enter(Enter), .Undo(Undo),
    .OpA(OpA), .OpB(OpB), .OpCode(OpCode),
    .LoadOpA(LoadOpA), .LoadOpB(LoadOpB), .LoadOpCode(LoadOpCode),
    .ToDisplaySel(ToDisplaySel), .State(State)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: slot = which item the user is on (0 A, 1 B, 2 opcode, 3 showing result);
  // loading marks the single cycle after a capture.
  int          m_slot;
  bit          m_loading;
  logic        m_prev_en, m_prev_un;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;

  task automatic model_reset();
    m_slot = 0; m_loading = 0; m_prev_en = 1'b1; m_prev_un = 1'b1;
    m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic model_clock();
    bit ee, ue;
    ee = Enter & ~m_prev_en;
    ue = Undo & ~m_prev_un;
    m_prev_en = Enter;
    m_prev_un = Undo;
    if (m_loading) begin
      m_loading = 0;
      m_slot = m_slot + 1;
    end else if (ue) begin
      if (m_slot > 0) m_slot = m_slot - 1;
    end else if (ee) begin
      if (m_slot == 3) m_slot = 0;
      else begin
        if (m_slot == 0) m_a = DataIn;
        else if (m_slot == 1) m_b = DataIn;
        else m_op = DataIn[1:0];
        m_loading = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [2:0] st;
    st = m_loading ? 3'(2 * m_slot + 1) : 3'(2 * m_slot);
    chk("state", 32'(State), 32'(st));
    chk("opa", 32'(OpA), 32'(m_a));
    chk("opb", 32'(OpB), 32'(m_b));
    chk("opcode", 32'(OpCode), 32'(m_op));
    chk("loada", 32'(LoadOpA), 32'(m_loading && m_slot == 0));
    chk("loadb", 32'(LoadOpB), 32'(m_loading && m_slot == 1));
    chk("loadop", 32'(LoadOpCode), 32'(m_loading && m_slot == 2));
    chk("dispsel", 32'(ToDisplaySel), 32'(!m_loading && m_slot == 3));
  endtask

  // Called at a negedge: drive, clock once, check at the following negedge.
  task automatic cycle(input logic en, input logic un, input logic [15:0] d);
    Enter = en; Undo = un; DataIn = d;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic        en;
    logic        un;
    logic [15:0] d;
    logic [2:0]  st;
    logic [2:0]  loads;  // {LoadOpCode, LoadOpB, LoadOpA}
    logic        disp;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int pulses;
    vecs[0]  = '{1, 0, 16'h1234, 3'd0, 3'b000, 0};
    vecs[1]  = '{0, 0, 16'h1234, 3'd0, 3'b000, 0};
    vecs[2]  = '{1, 0, 16'h1234, 3'd1, 3'b001, 0};
    vecs[3]  = '{1, 0, 16'h1234, 3'd2, 3'b000, 0};
    vecs[4]  = '{0, 0, 16'h00FF, 3'd2, 3'b000, 0};
    vecs[5]  = '{0, 1, 16'h00FF, 3'd0, 3'b000, 0};
    vecs[6]  = '{0, 0, 16'h00FF, 3'd0, 3'b000, 0};
    vecs[7]  = '{1, 0, 16'h00FF, 3'd1, 3'b001, 0};
    vecs[8]  = '{0, 0, 16'h0F0F, 3'd2, 3'b000, 0};
    vecs[9]  = '{1, 0, 16'h0F0F, 3'd3, 3'b010, 0};
    vecs[10] = '{0, 0, 16'h0002, 3'd4, 3'b000, 0};
    vecs[11] = '{1, 0, 16'h0002, 3'd5, 3'b100, 0};
    vecs[12] = '{0, 0, 16'h0002, 3'd6, 3'b000, 1};
    vecs[13] = '{0, 1, 16'h0002, 3'd4, 3'b000, 0};
    vecs[14] = '{0, 0, 16'h0001, 3'd4, 3'b000, 0};
    vecs[15] = '{1, 0, 16'h0001, 3'd5, 3'b100, 0};
    vecs[16] = '{0, 0, 16'h0001, 3'd6, 3'b000, 1};
    vecs[17] = '{1, 0, 16'h0001, 3'd0, 3'b000, 0};
    vecs[18] = '{0, 0, 16'hAAAA, 3'd0, 3'b000, 0};
    vecs[19] = '{1, 0, 16'hAAAA, 3'd1, 3'b001, 0};
    vecs[20] = '{0, 0, 16'h5555, 3'd2, 3'b000, 0};
    vecs[21] = '{1, 1, 16'h5555, 3'd0, 3'b000, 0};
    vecs[22] = '{0, 0, 16'h5555, 3'd0, 3'b000, 0};

    reset_n = 1'b0; Enter = 1'b1; Undo = 1'b0; DataIn = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    reset_n = 1'b1;

    // Scripted sequences, Enter held through reset release
    for (int i = 0; i < 23; i++) begin
      cycle(vecs[i].en, vecs[i].un, vecs[i].d);
      chk($sformatf("vec%0d_state", i), 32'(State), 32'(vecs[i].st));
      chk($sformatf("vec%0d_loads", i), 32'({LoadOpCode, LoadOpB, LoadOpA}), 32'(vecs[i].loads));
      chk($sformatf("vec%0d_disp", i), 32'(ToDisplaySel), 32'(vecs[i].disp));
    end
    chk("vec_opa_final", 32'(OpA), 32'h0000AAAA);
    chk("vec_opb_kept", 32'(OpB), 32'h00000F0F);
    chk("vec_opcode_final", 32'(OpCode), 32'h1);

    // Long hold in WAIT_OPA gives one capture only
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0, 16'hBEEF);
      if (LoadOpA) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("hold_state", 32'(State), 32'd2);
    chk("hold_opa", 32'(OpA), 32'h0000BEEF);
    cycle(1'b0, 1'b0, 16'h7777);
    cycle(1'b1, 1'b0, 16'h7777);
    chk("repress_state", 32'(State), 32'd3);

    // Asynchronous reset mid-load, away from any clock edge
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("areset_state", 32'(State), 32'd0);
    chk("areset_opa", 32'(OpA), 32'd0);
    chk("areset_opb", 32'(OpB), 32'd0);
    chk("areset_opcode", 32'(OpCode), 32'd0);
    chk("areset_disp", 32'(ToDisplaySel), 32'd0);
    chk("areset_loadb", 32'(LoadOpB), 32'd0);
    Enter = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 16'h0000);
    chk("undo_in_waita", 32'(State), 32'd0);
    cycle(1'b0, 1'b0, 16'h0000);

    // Random presses against the model, with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #1 reset_n = 1'b0;
        Enter = 1'($urandom_range(0, 1));
        Undo  = 1'($urandom_range(0, 1));
        model_reset();
        #1 check_model();
        @(negedge clk);
        reset_n = 1'b1;
      end
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
- FSM that sequences operand/opcode entry for the 16-bit switch-entry ALU calculator.
- Captures operand A, operand B and the opcode from the switch bus on Enter button presses.
- Drives the display-select line: 0 shows the switch bus, 1 shows the ALU result.
- Sits between the debounced buttons/switches and the ALU and display mux.

Parameters:
- WIDTH, 16, operand width in bits (switch bus, OpA, OpB).
- OPW, 2, opcode width; opcode taken from DataIn[OPW-1:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- DataIn  input  WIDTH  switch bus (static between presses).
- Enter  input  1  debounced Enter button, level, active-high.
- Undo  input  1  debounced Undo button, level, active-high.
- OpA  output  WIDTH  registered operand A to ALU.
- OpB  output  WIDTH  registered operand B to ALU.
- OpCode  output  OPW  registered ALU opcode.
- LoadOpA, LoadOpB, LoadOpCode  output  1 each  one-cycle pulse in the matching LOAD state.
- ToDisplaySel  output  1  display select: 0 = DataIn, 1 = ALU result.
- State  output  3  current state encoding, for LEDs.

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low, named `reset_n`.
- Reset values:
  - State = WAIT_OPA; OpA = OpB = 0; OpCode = 0.
  - All Load pulses = 0; ToDisplaySel = 0.
  - Edge-detect history registers = 1, so a button held through reset release gives no edge.
- Edge detection:
  - EnterEdge = Enter & ~Enter_q; UndoEdge = Undo & ~Undo_q.
  - Enter_q and Undo_q update every cycle in every state.
- State encoding (fixed): WAIT_OPA=0, LOAD_OPA=1, WAIT_OPB=2, LOAD_OPB=3, WAIT_OP=4, LOAD_OP=5, SHOW_RESULT=6. Code 7 is illegal and returns to WAIT_OPA next cycle.
- Transitions on EnterEdge (when UndoEdge = 0):
  - WAIT_OPA -> LOAD_OPA; OpA <= DataIn on that same edge.
  - WAIT_OPB -> LOAD_OPB; OpB <= DataIn.
  - WAIT_OP -> LOAD_OP; OpCode <= DataIn[OPW-1:0].
  - SHOW_RESULT -> WAIT_OPA; OpA, OpB and OpCode are retained, not cleared.
- LOAD states:
  - Last exactly one cycle, then go unconditionally to the next WAIT state: LOAD_OPA->WAIT_OPB, LOAD_OPB->WAIT_OP, LOAD_OP->SHOW_RESULT.
  - Edges arriving during a LOAD state are ignored.
- Load pulses: LoadOpX = 1 exactly while State = LOAD_X (Moore). The captured value is visible on OpX in the same cycle the pulse is high.
- Undo (on UndoEdge):
  - WAIT_OPB -> WAIT_OPA; WAIT_OP -> WAIT_OPB; SHOW_RESULT -> WAIT_OP.
  - WAIT_OPA stays in WAIT_OPA.
  - Registers are not modified by Undo.
- Simultaneous EnterEdge and UndoEdge in a WAIT or SHOW state: Undo wins and no capture occurs.
- ToDisplaySel = 1 iff State = SHOW_RESULT (Moore, registered with the state, glitch-free).
- Latency:
  - Press to capture: 1 cycle. OpX is valid in the cycle after the edge is sampled.
  - Third press to ToDisplaySel = 1: 2 cycles.
- Held button: one press yields exactly one edge regardless of hold duration.
- Reset asserted mid-sequence: immediate return to the reset values, independent of clk.

Test Plan:
1. Reset release with Enter held high -> State stays 0 and no LoadOpA pulse; release then press Enter with DataIn=16'h1234 -> LoadOpA high for one cycle, OpA=16'h1234, State=2.
2. Full sequence with DataIn=16'h00FF (Enter), 16'h0F0F (Enter), 16'h0002 (Enter) -> OpA=16'h00FF, OpB=16'h0F0F, OpCode=2'b10; ToDisplaySel=1 two cycles after the third edge sampled; State=6.
3. From SHOW_RESULT: press Undo -> State=4, ToDisplaySel=0, registers unchanged. Then Enter with DataIn=16'h0001 -> OpCode=2'b01, State=6.
4. In WAIT_OPB, Enter and Undo rise in the same cycle -> State=0, OpB unchanged, no LoadOpB pulse.
5. Hold Enter for 50 cycles in WAIT_OPA -> exactly one LoadOpA pulse and State=2; no progression to WAIT_OP until release and re-press.
6. Assert reset_n low asynchronously (between clk edges) while in LOAD_OPB -> OpA, OpB, OpCode and ToDisplaySel clear immediately and State=0; Undo pressed in WAIT_OPA -> State stays 0.
